// File: rtl/pipe_regfile_pkg.sv
// Shared constants and scan-state type for the pipelined register file.
package pipe_regfile_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/pipe_regfile_if.sv
// Read, write and dump-port bundle of pipe_regfile; slave is the register file side.
interface pipe_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) ();

  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              dump_req;
  logic              dump_busy;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_done;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, dump_req, dump_ready,
    input  rd_data1, rd_data2, dump_busy, dump_valid, dump_idx, dump_data, dump_done
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, dump_req, dump_ready,
    output rd_data1, rd_data2, dump_busy, dump_valid, dump_idx, dump_data, dump_done
  );

endinterface

// File: rtl/pipe_regfile_dump_fsm.sv
// Scan engine: walks every entry and presents it on a valid/ready dump port.
module regfile_dump_fsm
  import pipe_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_req,
  input  logic              dump_ready,
  input  logic [DATA_W-1:0] cap_data,
  output logic [ADDR_W-1:0] cap_idx_c,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  scan_state_e       state, state_nx;
  logic [ADDR_W-1:0] idx_nx;
  logic [DATA_W-1:0] data_nx;

  // Next state; cap_idx_c names the entry whose post-write value cap_data returns
  always_comb begin
    state_nx  = state;
    idx_nx    = dump_idx;
    data_nx   = dump_data;
    cap_idx_c = dump_idx + ADDR_W'(1);
    case (state)
      ST_IDLE: begin
        cap_idx_c = '0;
        if (dump_req) begin
          state_nx = ST_SCAN;
          idx_nx   = '0;
          data_nx  = cap_data;
        end
      end
      ST_SCAN: begin
        if (dump_ready) begin
          if (dump_idx == LAST_IDX) begin
            state_nx = ST_DONE;
            idx_nx   = '0;
          end else begin
            idx_nx  = dump_idx + ADDR_W'(1);
            data_nx = cap_data;
          end
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      dump_idx   <= '0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      state      <= state_nx;
      dump_idx   <= idx_nx;
      dump_data  <= data_nx;
      dump_valid <= (state_nx == ST_SCAN);
      dump_busy  <= (state_nx != ST_IDLE);
      dump_done  <= (state_nx == ST_DONE);
    end
  end

endmodule

// File: rtl/pipe_regfile.sv
// Decode-stage register file: 2 combinational reads, 1 write, hardware dump port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module pipe_regfile
  import pipe_regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic           clk,
  input logic           rst,
  pipe_regfile_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef REGFILE_BYPASS_EN
  localparam bit RD_BYPASS = 1'b1;
`else
  localparam bit RD_BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok_c;
  logic [ADDR_W-1:0] cap_idx_c;
  logic [DATA_W-1:0] cap_data_c;

  assign wr_ok_c = bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok_c) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Entry value as seen through the zero-register rule and, optionally, the write port
  function automatic logic [DATA_W-1:0] entry_val(input logic [ADDR_W-1:0] a, input logic fwd);
    if (ZERO_REG && (a == '0)) return '0;
    if (fwd && wr_ok_c && (a == bus.wr_addr)) return bus.wr_data;
    return mem[a];
  endfunction

  // Dump capture always takes the post-write value so the snapshot is coherent
  always_comb begin
    bus.rd_data1 = entry_val(bus.rd_addr1, RD_BYPASS);
    bus.rd_data2 = entry_val(bus.rd_addr2, RD_BYPASS);
    cap_data_c   = entry_val(cap_idx_c, 1'b1);
  end

  regfile_dump_fsm #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dump_fsm (
    .clk        (clk),
    .rst        (rst),
    .dump_req   (bus.dump_req),
    .dump_ready (bus.dump_ready),
    .cap_data   (cap_data_c),
    .cap_idx_c  (cap_idx_c),
    .dump_busy  (bus.dump_busy),
    .dump_valid (bus.dump_valid),
    .dump_idx   (bus.dump_idx),
    .dump_data  (bus.dump_data),
    .dump_done  (bus.dump_done)
  );

endmodule

// File: tb/tb_pipe_regfile.sv
// Self-checking bench for pipe_regfile: transaction-level model plus directed vectors.
module tb_pipe_regfile;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  pipe_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [AW-1:0] xq_idx[$];
  logic [DW-1:0] xq_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: register contents plus scan progress as "next entry to present"
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_scan, m_done;
  int            m_k;
  logic [DW-1:0] m_cap;

  function automatic logic [DW-1:0] post_write(input int a);
    if (a == 0) return '0;
    if (bus.wr_en && (bus.wr_addr == AW'(a))) return bus.wr_data;
    return m_mem[a];
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == '0) return '0;
    if (BYP && bus.wr_en && (bus.wr_addr == a)) return bus.wr_data;
    return m_mem[a];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
      m_scan <= 1'b0;
      m_done <= 1'b0;
      m_k    <= 0;
      m_cap  <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_scan && !m_done) begin
        if (bus.dump_req) begin
          m_scan <= 1'b1;
          m_k    <= 0;
          m_cap  <= post_write(0);
        end
      end else if (m_scan && bus.dump_ready) begin
        if (m_k == DEPTH - 1) begin
          m_scan <= 1'b0;
          m_done <= 1'b1;
          m_k    <= 0;
        end else begin
          m_k   <= m_k + 1;
          m_cap <= post_write(m_k + 1);
        end
      end
      if (bus.wr_en && (bus.wr_addr != '0)) m_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Every-cycle comparison against the model, plus transfer / done logging
  always @(negedge clk) begin
    chk("rd_data1", bus.rd_data1, exp_read(bus.rd_addr1));
    chk("rd_data2", bus.rd_data2, exp_read(bus.rd_addr2));
    chk("dump_valid", 32'(bus.dump_valid), 32'(m_scan));
    chk("dump_busy", 32'(bus.dump_busy), 32'(m_scan || m_done));
    chk("dump_done", 32'(bus.dump_done), 32'(m_done));
    chk("dump_idx", 32'(bus.dump_idx), 32'(m_k));
    if (m_scan) chk("dump_data", bus.dump_data, m_cap);
    if (bus.dump_valid && bus.dump_ready) begin
      xq_idx.push_back(bus.dump_idx);
      xq_data.push_back(bus.dump_data);
    end
    if (bus.dump_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start;
    start = done_cnt;
    for (int i = 0; i < 40 && done_cnt == start; i++) tick();
    chk(name, 32'(done_cnt != start), 32'd1);
  endtask

  task automatic start_dump();
    xq_idx.delete();
    xq_data.delete();
    bus.dump_ready = 1'b1;
    bus.dump_req   = 1'b1;
    tick();
    bus.dump_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int done0;
    bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.dump_req = 1'b0; bus.dump_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("rst_rd1", bus.rd_data1, 32'h0);
    chk("rst_busy", 32'(bus.dump_busy), 32'd0);
    chk("rst_valid", 32'(bus.dump_valid), 32'd0);
    chk("rst_done", 32'(bus.dump_done), 32'd0);
    chk("rst_idx", 32'(bus.dump_idx), 32'd0);
    chk("rst_data", bus.dump_data, 32'h0);
    rst = 1'b0;
    tick();

    // Basic write/read and the zero register
    wr(5'd3, 32'hDEADBEEF);
    bus.rd_addr1 = 5'd3; bus.rd_addr2 = 5'd3; #1;
    chk("rd1_e3", bus.rd_data1, 32'hDEADBEEF);
    chk("rd2_e3", bus.rd_data2, 32'hDEADBEEF);
    wr(5'd0, 32'h00001234);
    bus.rd_addr1 = 5'd0; bus.rd_addr2 = 5'd0; #1;
    chk("rd1_e0", bus.rd_data1, 32'h0);
    chk("rd2_e0", bus.rd_data2, 32'h0);

    // Same-cycle write and read
    bus.rd_addr1 = 5'd5;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hA5A5A5A5; #1;
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle_e5", bus.rd_data1, 32'hA5A5A5A5);
`else
    chk("same_cycle_e5", bus.rd_data1, 32'h0);
`endif
    tick();
    bus.wr_en = 1'b0; #1;
    chk("after_write_e5", bus.rd_data1, 32'hA5A5A5A5);
    bus.rd_addr1 = 5'd0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFFFFFF; #1;
    chk("same_cycle_e0", bus.rd_data1, 32'h0);
    tick();
    bus.wr_en = 1'b0;

    // Full dump, with a stray request mid-scan
    for (int k = 0; k < 32; k++) wr(AW'(k), 32'(k * 32'h11));
    done0 = done_cnt;
    start_dump();
    chk("d1_start_valid", 32'(bus.dump_valid), 32'd1);
    chk("d1_start_idx", 32'(bus.dump_idx), 32'd0);
    repeat (4) tick();
    bus.dump_req = 1'b1;
    tick();
    bus.dump_req = 1'b0;
    wait_done("d1_done_seen");
    repeat (3) tick();
    chk("d1_done_once", 32'(done_cnt - done0), 32'd1);
    chk("d1_count", 32'(xq_idx.size()), 32'd32);
    for (int k = 0; k < 32 && k < xq_idx.size(); k++) begin
      chk("d1_idx", 32'(xq_idx[k]), 32'(k));
      chk("d1_data", xq_data[k], 32'(k * 32'h11));
    end

    // Backpressure at idx 7 with a write to the held entry
    start_dump();
    repeat (7) tick();
    chk("bp_idx7", 32'(bus.dump_idx), 32'd7);
    chk("bp_data7", bus.dump_data, 32'h77);
    bus.dump_ready = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'hFFFF0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.wr_en = 1'b0;
      chk("bp_hold_idx", 32'(bus.dump_idx), 32'd7);
      chk("bp_hold_data", bus.dump_data, 32'h77);
    end
    bus.rd_addr1 = 5'd7; #1;
    chk("bp_e7_written", bus.rd_data1, 32'hFFFF0000);
    bus.dump_ready = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd8; bus.wr_data = 32'hFFFF0000;
    tick();
    bus.wr_en = 1'b0;
    chk("bp_idx8", 32'(bus.dump_idx), 32'd8);
    chk("bp_data8", bus.dump_data, 32'hFFFF0000);
    wait_done("bp_done_seen");
    repeat (2) tick();
    chk("bp_count", 32'(xq_idx.size()), 32'd32);
    if (xq_data.size() > 8) chk("bp_xfer7_old", xq_data[7], 32'h77);

    // Abort by reset at idx 10, then restart
    start_dump();
    repeat (10) tick();
    chk("ab_idx10", 32'(bus.dump_idx), 32'd10);
    done0 = done_cnt;
    rst = 1'b1; #1;
    chk("ab_valid_async", 32'(bus.dump_valid), 32'd0);
    chk("ab_busy_async", 32'(bus.dump_busy), 32'd0);
    tick();
    rst = 1'b0;
    bus.rd_addr1 = 5'd3; bus.rd_addr2 = 5'd8; #1;
    chk("ab_valid", 32'(bus.dump_valid), 32'd0);
    chk("ab_e3_clear", bus.rd_data1, 32'h0);
    chk("ab_e8_clear", bus.rd_data2, 32'h0);
    repeat (40) tick();
    chk("ab_no_done", 32'(done_cnt - done0), 32'd0);
    wr(5'd1, 32'h0BADF00D);
    start_dump();
    chk("re_valid", 32'(bus.dump_valid), 32'd1);
    chk("re_idx", 32'(bus.dump_idx), 32'd0);
    tick();
    chk("re_idx1", 32'(bus.dump_idx), 32'd1);
    chk("re_data1", bus.dump_data, 32'h0BADF00D);
    wait_done("re_done_seen");
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_regfile.md
# pipe_regfile

Parametrised successor to the CPU's general-purpose register file: two combinational read ports, one synchronous write port, asynchronous clear of all entries, and an optional write-to-read bypass for the pipelined datapath. It replaces simulation-only register printing with a hardware dump port: a scan engine streams every register out over a valid/ready handshake. It sits in the decode stage; the dump port feeds the debug/trace unit.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- rd_addr1  input  ADDR_W  read port 1 address
- rd_addr2  input  ADDR_W  read port 2 address
- rd_data1  output  DATA_W  read port 1 data, combinational
- rd_data2  output  DATA_W  read port 2 data, combinational
- wr_en  input  1  write enable
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- dump_req  input  1  start-scan request, sampled only in IDLE
- dump_busy  output  1  high in SCAN and DONE
- dump_valid  output  1  dump_idx/dump_data hold a valid entry
- dump_ready  input  1  consumer accepts the entry
- dump_idx  output  ADDR_W  index of the presented entry
- dump_data  output  DATA_W  value of the presented entry
- dump_done  output  1  one-cycle pulse after the last entry transfers

## Operation
- Storage: DEPTH x DATA_W flops. rst clears every entry to 0.
- Write: on a rising edge with wr_en=1, entry[wr_addr] <= wr_data. When ZERO_REG=1 and wr_addr=0, no write occurs.
- Read: rd_dataN = entry[rd_addrN]. When ZERO_REG=1 and rd_addrN=0, rd_dataN = 0.
- Scan FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN on dump_req=1. dump_idx is loaded with 0 and dump_data captures entry[0].
  - In SCAN, dump_valid=1. A transfer occurs on an edge with dump_valid & dump_ready.
  - On a transfer with dump_idx < DEPTH-1: dump_idx increments and dump_data captures entry[dump_idx+1].
  - On a transfer with dump_idx = DEPTH-1: the FSM moves to DONE. dump_valid drops and dump_idx wraps to 0.
  - DONE -> IDLE unconditionally after one cycle. dump_done=1 only in DONE.
  - dump_req is ignored in SCAN and DONE; there is no queueing.
- Capture coherency: dump_data is a register. It is stable while dump_valid=1 and dump_ready=0, even if the entry is rewritten meanwhile. If a capture edge coincides with a write to the captured index, the capture takes wr_data (post-write value), subject to the ZERO_REG rule.
- Normal reads and writes continue unaffected during a scan.

## Timing
- Reset values: dump_busy=0, dump_valid=0, dump_done=0, dump_idx=0, dump_data=0, FSM=IDLE. rd_data reflects the cleared storage (0).
- rst asserted mid-scan aborts immediately: no dump_done pulse, FSM returns to IDLE, storage is cleared.
- Write-to-read: a value written at edge N is visible on rd_data after edge N (zero-cycle combinational read of storage). Same-cycle behaviour depends on the bypass macro (see Configuration).
- Scan latency: dump_req high at edge N gives dump_valid=1 after edge N. With dump_ready held at 1, the DEPTH transfers occur on edges N+1..N+DEPTH and dump_done is high for the cycle after edge N+DEPTH.
- The earliest accepted new dump_req is at the edge that returns the FSM to IDLE +1, i.e. the first edge with FSM=IDLE.

## Configuration
- REGFILE_BYPASS_EN defined: when wr_en=1, rd_addrN=wr_addr, and the entry is writable, rd_dataN=wr_data in the same cycle (forwarding). The ZERO_REG rule still takes precedence.
- REGFILE_BYPASS_EN undefined: rd_dataN returns the stored, pre-write value during the write cycle. This mode is used when the pipeline forwards externally.

## Structure
- Shared package: the scan state enum (IDLE/SCAN/DONE) and the default DATA_W/ADDR_W constants used by the CPU top.
- One sub-module, regfile_dump_fsm, owns the state, dump_idx, the dump_data capture register and the handshake. Storage, read muxing and bypass stay in pipe_regfile.

## Test plan
- Reset: assert rst mid-operation → all reads return 0; dump outputs 0; FSM IDLE.
- Write entry 3=0xDEADBEEF, then read both ports at 3 → 0xDEADBEEF. Write 0x1234 to entry 0 (ZERO_REG=1) → reads 0.
- Same-cycle write/read of entry 5=0xA5A5A5A5 → rd_data1=0xA5A5A5A5 with REGFILE_BYPASS_EN, old value (0) without it.
- Dump with entry k preset to k*0x11 and dump_ready=1 → 32 transfers, idx 0..31 with data k*0x11 (entry 0 = 0), dump_done pulses once on the cycle after the 32nd transfer.
- Backpressure: hold dump_ready=0 at idx 7 for 5 cycles while writing 0xFFFF0000 to entry 7 → dump_data stays at the old value; write to entry 8 on the idx-7 transfer edge → idx 8 shows 0xFFFF0000.
- Abort/ignore: dump_req during SCAN → no restart; rst at idx 10 → dump_valid=0 next cycle, no dump_done, and a later dump_req restarts at idx 0.
